// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared types and helpers for the memory-stage controller.
// Holds the FSM state type, access-size codes and a size-to-bytes helper.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } mem_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic [3:0] size_bytes(input logic [1:0] sz);
        return 4'd1 << sz;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: extracts a load value from an aligned cache word.
// Ports: rdata (cache word), lane (byte offset), size, uns -> value.
module mem_load_align
    import mem_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int LW   = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [LW-1:0]   lane,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] value
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] mask;
    logic            msb;
    int              nbits;

    always_comb begin
        shifted = rdata >> {lane, 3'b000};
        nbits   = 8 * int'(size_bytes(size));
        mask    = '1;
        msb     = 1'b0;
        value   = shifted;
        // Full-width accesses pass through untouched.
        if (nbits < XLEN) begin
            mask  = (XLEN'(1) << nbits) - XLEN'(1);
            msb   = |(shifted & (XLEN'(1) << (nbits - 1)));
            value = shifted & mask;
            if (!uns && msb) begin
                value = value | ~mask;
            end
        end
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: EX/MEM to data-cache controller, IDLE/REQ/WAIT/DONE FSM.
// Ports: clk, reset (sync, active-high); in_* from EX/MEM with
// in_valid/in_ready; req_* to the cache with req_valid/req_ready;
// resp_valid/resp_rdata from the cache; out_* to MEM/WB with
// out_valid/out_ready. MEM_STAGE_MISALIGN_TRAP_EN: when defined,
// misaligned accesses skip the cache and raise out_misalign; otherwise
// they are aligned down and out_misalign is tied low.
module mem_stage_ctrl
    import mem_stage_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [XLEN-1:0]     in_wdata,
    input  logic                in_read,
    input  logic                in_write,
    input  logic [1:0]          in_size,
    input  logic                in_unsigned,
    output logic                req_valid,
    input  logic                req_ready,
    output logic [ADDR_W-1:0]   req_addr,
    output logic                req_write,
    output logic [XLEN-1:0]     req_wdata,
    output logic [XLEN/8-1:0]   req_wstrb,
    input  logic                resp_valid,
    input  logic [XLEN-1:0]     resp_rdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_data,
    output logic                out_misalign
);

    localparam int SW = XLEN / 8;
    localparam int LW = $clog2(SW);

    mem_state_t        state;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [SW-1:0]     wstrb_q;
    logic              write_q;
    logic [LW-1:0]     lane_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic [XLEN-1:0]   data_q;

    logic              is_mem;
    logic [1:0]        sz;
    logic [ADDR_W-1:0] ea;
    logic [ADDR_W-1:0] blk;
    logic [LW-1:0]     lane;
    logic [SW-1:0]     strb;
    logic [XLEN-1:0]   rep;
    logic [XLEN-1:0]   ext;

    // Request payload is computed at accept time and registered, so
    // req_* never depends combinationally on in_*.
    always_comb begin
        is_mem = in_read | in_write;
        sz     = in_size;
        if (XLEN == 32 && in_size == SZ_D) begin
            sz = SZ_W;
        end
        ea   = in_addr & ~(ADDR_W'(size_bytes(sz)) - ADDR_W'(1));
        lane = ea[LW-1:0];
        blk  = ea & ~ADDR_W'(SW - 1);
        // Wraps to all-ones when the access covers the whole word.
        strb = ((SW'(1) << size_bytes(sz)) - SW'(1)) << lane;
        rep  = in_wdata;
        unique case (1'b1)
            sz == SZ_B: rep = {SW{in_wdata[7:0]}};
            sz == SZ_H: rep = {(SW / 2){in_wdata[15:0]}};
            sz == SZ_W: rep = {(SW / 4){in_wdata[31:0]}};
            default:    rep = in_wdata;
        endcase
    end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic mis;
    logic mis_q;

    always_comb begin
        mis = is_mem &&
              (((in_addr & (ADDR_W'(size_bytes(in_size)) - ADDR_W'(1)))
                != '0) ||
               (XLEN == 32 && in_size == SZ_D));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mis_q <= mis;
        end
    end

    assign out_misalign = mis_q;
`else
    assign out_misalign = 1'b0;
`endif

    mem_load_align #(
        .XLEN (XLEN),
        .LW   (LW)
    ) u_align (
        .rdata (resp_rdata),
        .lane  (lane_q),
        .size  (size_q),
        .uns   (uns_q),
        .value (ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            write_q <= 1'b0;
            lane_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        addr_q  <= blk;
                        wdata_q <= rep;
                        wstrb_q <= strb;
                        write_q <= in_write;
                        lane_q  <= lane;
                        size_q  <= sz;
                        uns_q   <= in_unsigned;
                        data_q  <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        state <= (is_mem && !mis) ? REQ : DONE;
`else
                        state <= is_mem ? REQ : DONE;
`endif
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        data_q <= write_q ? '0 : ext;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign req_valid = (state == REQ);
    assign out_valid = (state == DONE);
    assign req_addr  = addr_q;
    assign req_write = write_q;
    assign req_wdata = wdata_q;
    assign req_wstrb = wstrb_q;
    assign out_data  = data_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: randomized self-checking bench for mem_stage_ctrl.
// Drives and samples on the falling edge; XLEN = ADDR_W = 64.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic        in_read;
    logic        in_write;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic        req_write;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_misalign;

    int    errors = 0;
    int    checks = 0;
    string cur    = "init";

    always #5 clk = ~clk;

    mem_stage_ctrl #(
        .XLEN   (64),
        .ADDR_W (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_wdata     (in_wdata),
        .in_read      (in_read),
        .in_write     (in_write),
        .in_size      (in_size),
        .in_unsigned  (in_unsigned),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_write    (req_write),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_misalign (out_misalign)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got=%h exp=%h", cur, tag, got, exp);
        end
    endtask

    // Reference: byte-level view of the access rules.
    task automatic model(input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wd,
                         input logic [63:0] rdata,
                         output bit go, output logic [63:0] raddr,
                         output logic [63:0] strb,
                         output logic [63:0] wrep,
                         output logic [63:0] res, output bit mis);
        int          n;
        int          lane;
        logic [63:0] ea;
        logic [63:0] v;
        n   = 1 << sz;
        go  = rd | wr;
        mis = 1'b0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        if (go && (addr % n) != 0) begin
            go  = 1'b0;
            mis = 1'b1;
        end
`endif
        ea    = addr - (addr % n);
        lane  = int'(ea % 8);
        raddr = ea - 64'(lane);
        strb  = '0;
        wrep  = '0;
        for (int i = 0; i < 8; i++) begin
            strb[i]        = (i >= lane) && (i < lane + n);
            wrep[8*i +: 8] = wd[8*(i % n) +: 8];
        end
        res = '0;
        if (go && rd) begin
            v = '0;
            for (int i = 0; i < n; i++) begin
                v[8*i +: 8] = rdata[8*(lane + i) +: 8];
            end
            if (!uns && n < 8 && v[8*n-1]) begin
                v = v - (64'd1 << (8 * n));
            end
            res = v;
        end
    endtask

    task automatic txn(input logic rd, input logic wr,
                       input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] rdata,
                       input int rs, input int ws, input int os);
        bit          go;
        bit          mis;
        logic [63:0] raddr;
        logic [63:0] strb;
        logic [63:0] wrep;
        logic [63:0] res;
        model(rd, wr, sz, uns, addr, wd, rdata,
              go, raddr, strb, wrep, res, mis);
        check("idle_in_ready", in_ready, 1);
        in_valid    = 1'b1;
        in_read     = rd;
        in_write    = wr;
        in_size     = sz;
        in_unsigned = uns;
        in_addr     = addr;
        in_wdata    = wd;
        @(negedge clk);
        // Scramble inputs: outputs must come from captured state.
        in_valid    = 1'b0;
        in_read     = 1'($urandom);
        in_write    = 1'b0;
        in_size     = 2'($urandom);
        in_unsigned = 1'($urandom);
        in_addr     = {$urandom, $urandom};
        in_wdata    = {$urandom, $urandom};
        if (go) begin
            for (int i = 0; i <= rs; i++) begin
                check("req_valid", req_valid, 1);
                check("req_addr", req_addr, raddr);
                check("req_wstrb", req_wstrb, strb);
                check("req_wdata", req_wdata, wrep);
                check("req_write", req_write, wr);
                check("req_in_ready", in_ready, 0);
                check("req_out_valid", out_valid, 0);
                req_ready  = (i == rs);
                resp_valid = 1'($urandom);
                resp_rdata = {$urandom, $urandom};
                @(negedge clk);
            end
            req_ready = 1'b0;
            for (int i = 0; i <= ws; i++) begin
                check("wait_req_valid", req_valid, 0);
                check("wait_out_valid", out_valid, 0);
                check("wait_in_ready", in_ready, 0);
                resp_valid = (i == ws);
                resp_rdata = (i == ws) ? rdata : {$urandom, $urandom};
                @(negedge clk);
            end
        end else begin
            check("no_req_valid", req_valid, 0);
        end
        for (int i = 0; i <= os; i++) begin
            check("out_valid", out_valid, 1);
            check("out_data", out_data, res);
            check("out_misalign", out_misalign, mis);
            check("done_in_ready", in_ready, 0);
            check("done_req_valid", req_valid, 0);
            out_ready  = (i == os);
            resp_valid = 1'($urandom);
            resp_rdata = {$urandom, $urandom};
            @(negedge clk);
        end
        out_ready  = 1'b0;
        resp_valid = 1'b0;
        check("post_out_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int r;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_addr     = '0;
        in_wdata    = '0;
        in_read     = 1'b0;
        in_write    = 1'b0;
        in_size     = '0;
        in_unsigned = 1'b0;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        cur = "reset";
        check("in_ready", in_ready, 1);
        check("req_valid", req_valid, 0);
        check("req_write", req_write, 0);
        check("req_wstrb", req_wstrb, 0);
        check("req_addr", req_addr, 0);
        check("req_wdata", req_wdata, 0);
        check("out_valid", out_valid, 0);
        check("out_data", out_data, 0);
        check("out_misalign", out_misalign, 0);

        cur = "nonmem";
        txn(0, 0, 2'd3, 0, 64'h1234_5678, 64'hFFFF, 64'h0, 0, 0, 0);
        cur = "lb_signed";
        txn(1, 0, 2'd0, 0, 64'h1003, 64'h0,
            64'h0000_0000_8000_0000, 0, 0, 0);
        cur = "sh";
        txn(0, 1, 2'd1, 0, 64'h2006, 64'hABCD, 64'hDEAD_BEEF, 0, 0, 0);
        cur = "backpressure";
        txn(1, 0, 2'd2, 1, 64'h4008, 64'h0,
            64'h8765_4321_F00D_CAFE, 4, 2, 3);
        cur = "lw_misalign";
        txn(1, 0, 2'd2, 0, 64'h3002, 64'h0,
            64'hCAFE_BABE_8123_4567, 0, 0, 0);
        cur = "ld_full";
        txn(1, 0, 2'd3, 0, 64'h7000, 64'h0,
            64'hFEDC_BA98_7654_3210, 1, 1, 1);

        cur = "rst_wait";
        in_valid = 1'b1;
        in_read  = 1'b1;
        in_write = 1'b0;
        in_size  = 2'd3;
        in_addr  = 64'h5000;
        @(negedge clk);
        in_valid  = 1'b0;
        in_read   = 1'b0;
        req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        check("in_wait", req_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        resp_valid = 1'b1;
        resp_rdata = 64'h1111_2222_3333_4444;
        @(negedge clk);
        resp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("out_valid", out_valid, 0);
            check("in_ready", in_ready, 1);
            check("req_valid", req_valid, 0);
            check("out_data", out_data, 0);
            @(negedge clk);
        end

        cur = "random";
        for (int k = 0; k < 80; k++) begin
            r = int'($urandom_range(0, 9));
            txn(r >= 1 && r < 6, r >= 6, 2'($urandom),
                1'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, {$urandom, $urandom},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
